// File: rtl/inputtest_pkg.sv
// Shared types and sizing for the SoC RAM port arbiter.
package inputtest_pkg;
  localparam int unsigned RAM_AW       = 14;
  localparam int unsigned DL_INDEX_MAX = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DL_WR    = 3'd1,
    CPU_WR   = 3'd2,
    CPU_RD   = 3'd3,
    CPU_RDAT = 3'd4
  } arb_state_t;
endpackage

// File: rtl/dl_pending.sv
// One-entry download byte buffer with host back-pressure and sticky overrun flag.
module dl_pending
  import inputtest_pkg::*;
#(
  parameter int unsigned AW = RAM_AW,
  parameter int unsigned DW = 8
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          dl_act,
  input  logic          dn_wr,
  input  logic [AW-1:0] dn_addr,
  input  logic [DW-1:0] dn_data,
  input  logic          clr,
  output logic          pend_v,
  output logic [AW-1:0] pend_a,
  output logic [DW-1:0] pend_d,
  output logic          dn_wait,
  output logic          dl_overrun
);
  logic load;
  logic drop;
  logic pend_v_nxt;

  // A strobe landing on the clearing cycle is taken: clear-then-load.
  always_comb begin
    load       = dl_act & dn_wr & (~pend_v | clr);
    drop       = dl_act & dn_wr & pend_v & ~clr;
    pend_v_nxt = load | (pend_v & ~clr);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pend_v     <= 1'b0;
      pend_a     <= '0;
      pend_d     <= '0;
      dn_wait    <= 1'b0;
      dl_overrun <= 1'b0;
    end else begin
      pend_v  <= pend_v_nxt;
      dn_wait <= pend_v_nxt;
      if (load) begin
        pend_a <= dn_addr;
        pend_d <= dn_data;
      end
      if (drop) dl_overrun <= 1'b1;
    end
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port RAM owner: download stream has fixed priority over CPU req/ack accesses.
module ram_port_arbiter
  import inputtest_pkg::*;
#(
  parameter int unsigned AW        = RAM_AW,
  parameter int unsigned DW        = 8,
  parameter int unsigned INDEX_MAX = DL_INDEX_MAX
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          dn_download,
  input  logic [7:0]    dn_index,
  input  logic          dn_wr,
  input  logic [AW-1:0] dn_addr,
  input  logic [DW-1:0] dn_data,
  output logic          dn_wait,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_hold,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata,
  output logic          dl_done,
  output logic          dl_overrun
);
  arb_state_t    state;
  logic          dl_act;
  logic          dl_act_q;
  logic          dl_fall;
  logic          done_arm;
  logic          init_q;
  logic          grant;
  logic          pend_v;
  logic [AW-1:0] pend_a;
  logic [DW-1:0] pend_d;

  dl_pending #(.AW(AW), .DW(DW)) u_pend (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .dl_act     (dl_act),
    .dn_wr      (dn_wr),
    .dn_addr    (dn_addr),
    .dn_data    (dn_data),
    .clr        (state == DL_WR),
    .pend_v     (pend_v),
    .pend_a     (pend_a),
    .pend_d     (pend_d),
    .dn_wait    (dn_wait),
    .dl_overrun (dl_overrun)
  );

  // Grants also stop on the raw dl_act so a request racing the download start
  // loses; the ack cycle is excluded since the CPU still holds cpu_req there.
  always_comb begin
    dl_act  = dn_download & (32'(dn_index) <= INDEX_MAX);
    dl_fall = dl_act_q & ~dl_act;
    grant   = cpu_req & ~cpu_hold & ~dl_act & ~cpu_ack;
    dl_done = done_arm & ~dl_act & ~pend_v & (state == IDLE);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_v) begin
            ram_addr  <= pend_a;
            ram_wdata <= pend_d;
            ram_we    <= 1'b1;
            state     <= DL_WR;
          end else if (grant) begin
            ram_addr  <= cpu_addr;
            ram_wdata <= cpu_wdata;
            ram_we    <= cpu_we;
            state     <= cpu_we ? CPU_WR : CPU_RD;
          end
        end
        DL_WR: begin
          ram_we <= 1'b0;
          state  <= IDLE;
        end
        CPU_WR: begin
          ram_we  <= 1'b0;
          cpu_ack <= 1'b1;
          state   <= IDLE;
        end
        CPU_RD: state <= CPU_RDAT;
        CPU_RDAT: begin
          cpu_rdata <= ram_rdata;
          cpu_ack   <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // init_q keeps the CPU held through the first edge after reset release.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_act_q <= 1'b0;
      done_arm <= 1'b0;
      init_q   <= 1'b1;
      cpu_hold <= 1'b1;
    end else begin
      dl_act_q <= dl_act;
      init_q   <= 1'b0;
      done_arm <= dl_fall | (done_arm & ~dl_done);
      cpu_hold <= init_q | dl_act | pend_v | dl_fall | (done_arm & ~dl_done);
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a synchronous RAM and a scoreboard memory.
module tb_ram_port_arbiter;
  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        dn_download;
  logic [7:0]  dn_index;
  logic        dn_wr;
  logic [13:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wait;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_hold;
  logic [13:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic        dl_done;
  logic        dl_overrun;

  logic [7:0]  mem     [0:16383];
  logic [7:0]  ref_mem [0:16383];

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int long_we  = 0;
  int done_cnt = 0;
  int ack_cnt  = 0;
  logic we_prev = 1'b0;

  always #5 clk_sys = ~clk_sys;

  ram_port_arbiter #(.AW(14), .DW(8), .INDEX_MAX(1)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .dn_download (dn_download),
    .dn_index    (dn_index),
    .dn_wr       (dn_wr),
    .dn_addr     (dn_addr),
    .dn_data     (dn_data),
    .dn_wait     (dn_wait),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .cpu_hold    (cpu_hold),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_we      (ram_we),
    .ram_rdata   (ram_rdata),
    .dl_done     (dl_done),
    .dl_overrun  (dl_overrun)
  );

  // Synchronous RAM plus event counters.
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    if (ram_we) we_cnt++;
    if (ram_we && we_prev) long_we++;
    we_prev = ram_we;
    if (dl_done) done_cnt++;
    if (cpu_ack) ack_cnt++;
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic dl_byte(input logic [13:0] a, input logic [7:0] d, output bit ok);
    dn_addr = a;
    dn_data = d;
    dn_wr   = 1'b1;
    step();
    dn_wr = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (!dn_wait) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (dl_done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic cpu_access(input logic we, input logic [13:0] a, input logic [7:0] wd,
                            output logic [7:0] rd, output int lat);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    lat = -1;
    rd  = 'x;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (cpu_ack) begin
        lat = k;
        rd  = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({dn_wait, ram_we, cpu_ack, dl_done, dl_overrun, ram_addr, ram_wdata, cpu_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b ack=%b done=%b ovr=%b wait=%b addr=%h wd=%h rd=%h, want all 0",
               ram_we, cpu_ack, dl_done, dl_overrun, dn_wait, ram_addr, ram_wdata, cpu_rdata);
    end
    n_checks++;
    if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold: got %b want 1", cpu_hold); end
    reset_n = 1'b1;
    step();
    n_checks++;
    if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL hold_edge1: got %b want 1", cpu_hold); end
    step();
    n_checks++;
    if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL hold_edge2: got %b want 0", cpu_hold); end
  endtask

  task automatic test_download();
    logic [13:0] ra [8];
    logic [7:0]  rdv [8];
    bit ok;
    bit seen;
    int we0;
    int done0;
    we0   = we_cnt;
    done0 = done_cnt;
    dn_index    = 8'd0;
    dn_download = 1'b1;
    step();
    step();
    n_checks++;
    if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL dl_hold: got %b want 1", cpu_hold); end
    // First byte with exact latency.
    dn_addr = 14'h0000;
    dn_data = 8'h11;
    dn_wr   = 1'b1;
    step();
    dn_wr = 1'b0;
    n_checks++;
    if ({dn_wait, ram_we} !== 2'b10) begin n_fail++; $display("FAIL dl_t1: got wait,we=%b%b want 10", dn_wait, ram_we); end
    step();
    n_checks++;
    if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 14'h0000, 8'h11}) begin
      n_fail++;
      $display("FAIL dl_t2: got we=%b addr=%h data=%h want 1/0000/11", ram_we, ram_addr, ram_wdata);
    end
    step();
    n_checks++;
    if ({dn_wait, ram_we} !== 2'b00) begin n_fail++; $display("FAIL dl_t3: got wait,we=%b%b want 00", dn_wait, ram_we); end
    ref_mem[14'h0000] = 8'h11;
    dl_byte(14'h0001, 8'h22, ok);
    ref_mem[14'h0001] = 8'h22;
    dl_byte(14'h0002, 8'h33, ok);
    ref_mem[14'h0002] = 8'h33;
    for (int i = 0; i < 8; i++) begin
      ra[i]  = 14'h0100 + 14'($urandom_range(0, 255));
      rdv[i] = 8'($urandom);
      dl_byte(ra[i], rdv[i], ok);
      ref_mem[ra[i]] = rdv[i];
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL dl_wait_timeout: byte %0d dn_wait stuck, want low", i); end
    end
    dn_download = 1'b0;
    wait_done(seen);
    n_checks++;
    if (!seen || cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL dl_done_pulse: got seen=%b hold=%b want 1/1", seen, cpu_hold);
    end
    step();
    n_checks++;
    if ({cpu_hold, dl_done} !== 2'b00) begin n_fail++; $display("FAIL dl_hold_drop: got hold,done=%b%b want 00", cpu_hold, dl_done); end
    n_checks++;
    if (we_cnt - we0 != 11 || long_we != 0 || done_cnt - done0 != 1) begin
      n_fail++;
      $display("FAIL dl_counts: got we=%0d long=%0d done=%0d want 11/0/1", we_cnt - we0, long_we, done_cnt - done0);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (mem[i] !== ref_mem[i]) begin n_fail++; $display("FAIL dl_mem: addr %0d got %h want %h", i, mem[i], ref_mem[i]); end
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (mem[ra[i]] !== ref_mem[ra[i]]) begin
        n_fail++;
        $display("FAIL dl_mem_rand: addr %h got %h want %h", ra[i], mem[ra[i]], ref_mem[ra[i]]);
      end
    end
  endtask

  task automatic test_bad_index();
    bit ok;
    int we0;
    int done0;
    we0   = we_cnt;
    done0 = done_cnt;
    dn_index    = 8'd2;
    dn_download = 1'b1;
    step();
    dl_byte(14'h0005, 8'h77, ok);
    n_checks++;
    if (dn_wait !== 1'b0) begin n_fail++; $display("FAIL idx_wait: got %b want 0", dn_wait); end
    repeat (3) step();
    n_checks++;
    if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL idx_hold: got %b want 0", cpu_hold); end
    dn_download = 1'b0;
    repeat (4) step();
    n_checks++;
    if (we_cnt != we0 || done_cnt != done0 || mem[5] !== ref_mem[5]) begin
      n_fail++;
      $display("FAIL idx_ignored: got we=%0d done=%0d mem=%h want 0/0/%h", we_cnt - we0, done_cnt - done0, mem[5], ref_mem[5]);
    end
  endtask

  task automatic test_overrun();
    logic [13:0] a1;
    logic [13:0] a2;
    logic [7:0]  d1;
    logic [7:0]  d2;
    bit seen;
    int we0;
    a1 = 14'h0800 + 14'($urandom_range(0, 63));
    a2 = a1 + 14'd100;
    d1 = 8'($urandom_range(1, 127));
    d2 = d1 + 8'd128;
    we0 = we_cnt;
    n_checks++;
    if (dl_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_before: got %b want 0", dl_overrun); end
    dn_index    = 8'd1;
    dn_download = 1'b1;
    step();
    dn_addr = a1; dn_data = d1; dn_wr = 1'b1;
    step();
    dn_addr = a2; dn_data = d2;
    step();
    dn_wr = 1'b0;
    ref_mem[a1] = d1;
    repeat (4) step();
    dn_download = 1'b0;
    wait_done(seen);
    step();
    n_checks++;
    if (dl_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", dl_overrun); end
    n_checks++;
    if (we_cnt - we0 != 1 || mem[a1] !== ref_mem[a1] || mem[a2] !== ref_mem[a2]) begin
      n_fail++;
      $display("FAIL ovr_mem: got we=%0d m1=%h m2=%h want 1/%h/%h", we_cnt - we0, mem[a1], mem[a2], ref_mem[a1], ref_mem[a2]);
    end
  endtask

  task automatic test_cpu();
    logic [7:0]  rd;
    logic [13:0] a;
    logic [7:0]  d;
    int lat;
    cpu_access(1'b1, 14'h1FFF, 8'hA5, rd, lat);
    ref_mem[14'h1FFF] = 8'hA5;
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL cpu_wr_lat: got %0d want 2", lat); end
    step();
    cpu_access(1'b0, 14'h1FFF, 8'h00, rd, lat);
    n_checks++;
    if (lat != 3 || rd !== 8'hA5) begin n_fail++; $display("FAIL cpu_rd: got lat=%0d data=%h want 3/a5", lat, rd); end
    for (int i = 0; i < 16; i++) begin
      a = 14'h3F00 + 14'($urandom_range(0, 7));
      d = 8'($urandom);
      step();
      if ($urandom_range(0, 1) == 1) begin
        cpu_access(1'b1, a, d, rd, lat);
        ref_mem[a] = d;
        n_checks++;
        if (lat != 2) begin n_fail++; $display("FAIL cpu_rand_wr: addr %h got lat %0d want 2", a, lat); end
      end else begin
        cpu_access(1'b0, a, 8'h00, rd, lat);
        n_checks++;
        if (lat != 3 || rd !== ref_mem[a]) begin
          n_fail++;
          $display("FAIL cpu_rand_rd: addr %h got lat=%0d data=%h want 3/%h", a, lat, rd, ref_mem[a]);
        end
      end
    end
  endtask

  task automatic test_race();
    logic [13:0] x;
    logic [7:0]  d;
    bit seen;
    int ack0;
    int lat;
    x = 14'h2000 + 14'($urandom_range(0, 255));
    d = 8'($urandom);
    step();
    dn_index    = 8'd0;
    dn_download = 1'b1;
    dn_addr = x; dn_data = d; dn_wr = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = x;
    ack0 = ack_cnt;
    step();
    dn_wr = 1'b0;
    for (int k = 0; k < 16 && dn_wait; k++) step();
    dn_download = 1'b0;
    ref_mem[x] = d;
    wait_done(seen);
    n_checks++;
    if (!seen || ack_cnt != ack0 || cpu_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL race_order: got done=%b acks=%0d want 1/0", seen, ack_cnt - ack0);
    end
    lat = -1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (cpu_ack) begin
        lat = k;
        break;
      end
    end
    n_checks++;
    if (lat != 4 || cpu_rdata !== ref_mem[x]) begin
      n_fail++;
      $display("FAIL race_read: got lat=%0d data=%h want 4/%h", lat, cpu_rdata, ref_mem[x]);
    end
    cpu_req = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    dn_download = 1'b0;
    dn_index    = 8'd0;
    dn_wr       = 1'b0;
    dn_addr     = '0;
    dn_data     = '0;
    cpu_req     = 1'b0;
    cpu_we      = 1'b0;
    cpu_addr    = '0;
    cpu_wdata   = '0;
    reset_n     = 1'b0;
    test_reset();
    test_download();
    test_bad_index();
    test_overrun();
    test_cpu();
    test_race();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Sole owner of the SoC program/data RAM's single port, shared between the HPS download stream and the SoC CPU. Downloaded bytes go through a one-entry buffer that back-pressures the host via `dn_wait`. CPU accesses use a req/ack handshake. The block holds the CPU in reset for the duration of a download and pulses `dl_done` when the image is fully committed.

## Interface
- `AW`, 14: RAM address width (16 KiB).
- `DW`, 8: data width for download, CPU and RAM.
- `INDEX_MAX`, 1: highest `dn_index` accepted; indices above it are ignored.

Ports:
- `clk_sys` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `dn_download` in 1: download in progress.
- `dn_index` in 8: download file index.
- `dn_wr` in 1: one-cycle write strobe.
- `dn_addr` in AW: download byte address.
- `dn_data` in DW: download byte.
- `dn_wait` out 1: host must not strobe `dn_wr` while high.
- `cpu_req` in 1: CPU request, held high until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in AW; `cpu_wdata` in DW: CPU address and write data.
- `cpu_rdata` out DW: read data, valid in the `cpu_ack` cycle.
- `cpu_ack` out 1: one-cycle completion.
- `cpu_hold` out 1: CPU reset request to the SoC.
- `ram_addr` out AW; `ram_wdata` out DW; `ram_we` out 1: registered RAM controls.
- `ram_rdata` in DW: synchronous RAM output, valid one cycle after address.
- `dl_done` out 1: one-cycle pulse when download finished and committed.
- `dl_overrun` out 1: sticky; set when `dn_wr` arrives while the buffer is full.

## Operation
**Download active**
- `dl_act = dn_download & (dn_index <= INDEX_MAX)`.
- `dn_wr` with `dl_act` low is ignored. It is not buffered and does not affect `dn_wait`.

**Pending buffer (`pend_v`, `pend_a`, `pend_d`)**
- Accepted `dn_wr` loads the buffer.
- `dn_wait` is the registered value of `pend_v`.
- `dn_wr` while `pend_v` is set: the write is dropped and `dl_overrun` sets. `dl_overrun` clears only on reset.

**FSM states:** `IDLE`, `DL_WR`, `CPU_WR`, `CPU_RD`, `CPU_RDAT`.
- `IDLE`, `pend_v` set: go to `DL_WR`. Drive `ram_addr` = `pend_a`, `ram_wdata` = `pend_d`, `ram_we` = 1. Fixed priority: download beats CPU.
- `IDLE`, `cpu_req` & !`cpu_hold`:
  - Write: go to `CPU_WR`, `ram_we` = 1.
  - Read: go to `CPU_RD`, `ram_we` = 0.
  - In both cases `ram_addr` = `cpu_addr`.
- `DL_WR`: clear `pend_v`, `ram_we` = 0, go to `IDLE`.
- `CPU_WR`: `ram_we` = 0, assert `cpu_ack`, go to `IDLE`.
- `CPU_RD`: wait one cycle for RAM latency, go to `CPU_RDAT`.
- `CPU_RDAT`: `cpu_rdata` = `ram_rdata`, assert `cpu_ack`, go to `IDLE`.

**CPU hold and completion**
- `cpu_hold` is registered: `dl_act | pend_v | fsm != IDLE-after-download`.
- `dl_act` falling edge arms `dl_done`. The pulse fires in the first cycle with `!pend_v` and FSM in `IDLE`.
- `cpu_hold` drops in the cycle after `dl_done`.
- A CPU transaction already in flight when `dl_act` rises completes normally. No new CPU grants are made after that.

**Width rules**
- Addresses are taken as-is (AW bits); the top level truncates the ioctl address.
- No wrap detection.

## Timing
**Reset values:** all outputs 0 except `cpu_hold` = 1. FSM returns to `IDLE` and `pend_v` clears.

**Latency**
- Download: `dn_wr` at cycle t → `dn_wait` high at t+1 → `ram_we` at t+2 → `dn_wait` low at t+3. Minimum 3 cycles per byte.
- CPU write: `cpu_req` sampled in `IDLE` at t → `ram_we` t+1 → `cpu_ack` t+2.
- CPU read: `cpu_req` at t → `cpu_ack`/`cpu_rdata` at t+3.
- `cpu_hold` after reset release: drops at the second edge if `dl_act` is low.

**Simultaneous events**
- `cpu_req` and `pend_v` both present in `IDLE`: download is served first.
- `dn_wr` in the same cycle the buffer clears in `DL_WR`: accepted (clear-then-load).

**Reset mid-operation:** pending byte lost, no ack, no `dl_done`.

## Structure
- Shared package `inputtest_pkg`:
  - `arb_state_t` enum (5 states above).
  - `RAM_AW` = 14.
  - `DL_INDEX_MAX` = 1.
- Sub-module `dl_pending`: one-entry buffer holding `pend_v`/`pend_a`/`pend_d`, the overrun flag and the `dn_wait` register.
- FSM and hold/done logic stay in `ram_port_arbiter`.

## Test plan
1. Reset with `reset_n` = 0 → all outputs 0, `cpu_hold` = 1. Release → `cpu_hold` = 0 two edges later.
2. Download index 0, bytes `0x11`/`0x22`/`0x33` to addr `0x0000`–`0x0002`, host obeying `dn_wait` → RAM holds those values, three single-cycle `ram_we` pulses, one `dl_done` after the last write, `cpu_hold` low one cycle later.
3. Download with index 2 → no RAM writes, `dn_wait` stays 0, no `dl_done`.
4. Two `dn_wr` on consecutive cycles → second is dropped, `dl_overrun` = 1, only the first byte is written.
5. CPU write `0xA5` to `0x1FFF`, then read `0x1FFF` → `cpu_ack` at t+2 and t+3 respectively, `cpu_rdata` = `0xA5`.
6. `cpu_req` read rising in the same cycle `dl_act` rises with a pending byte → download write first, CPU never acked until after `dl_done`. Read issued after hold release completes normally.
